// File: rtl/text_buffer_pkg.sv
// rtl/text_buffer_pkg.sv - shared types and constants for the text buffer controller
package text_buffer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_FF = 8'h0C;

    localparam int         DEF_COLS       = 80;
    localparam int         DEF_ROWS       = 30;
    localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

endpackage

// File: rtl/text_buffer_if.sv
// rtl/text_buffer_if.sv - serial, VGA, readback and RAM-side signals of the text buffer
interface text_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  vga_ren;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic [DATA_WIDTH-1:0] vga_data;
    logic                  rb_valid;
    logic                  rb_ready;
    logic [ADDR_WIDTH-1:0] rb_addr;
    logic [DATA_WIDTH-1:0] rb_data;
    logic                  rb_data_valid;
    logic                  ram_wen;
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_ren;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [6:0]            cursor_col;
    logic [4:0]            cursor_row;
    logic                  busy;

    modport slave (
        input  wr_valid, wr_data, vga_ren, vga_addr, rb_valid, rb_addr, ram_dout,
        output wr_ready, vga_data, rb_ready, rb_data, rb_data_valid,
               ram_wen, ram_addr_a, ram_din, ram_ren, ram_addr_b,
               cursor_col, cursor_row, busy
    );

    modport master (
        output wr_valid, wr_data, vga_ren, vga_addr, rb_valid, rb_addr, ram_dout,
        input  wr_ready, vga_data, rb_ready, rb_data, rb_data_valid,
               ram_wen, ram_addr_a, ram_din, ram_ren, ram_addr_b,
               cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - cursor row/column with wrap rules and linear RAM address
module text_cursor
    import text_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance_i,
    input  logic                  cr_i,
    input  logic                  lf_i,
    input  logic                  bs_i,
    input  logic                  home_i,
    output logic [6:0]            col_o,
    output logic [4:0]            row_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [6:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [4:0] row_next;

    // Row step shared by column wrap and line feed; no scrolling, bottom row wraps to top
    assign row_next = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

    // Next cursor position; home wins, then printable advance, then control codes
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home_i) begin
            col_d = 7'd0;
            row_d = 5'd0;
        end else if (advance_i) begin
            if (col_q == LAST_COL) begin
                col_d = 7'd0;
                row_d = row_next;
            end else begin
                col_d = col_q + 7'd1;
            end
        end else if (cr_i) begin
            col_d = 7'd0;
        end else if (lf_i) begin
            row_d = row_next;
        end else if (bs_i && (col_q != 7'd0)) begin
            col_d = col_q - 7'd1;
        end
    end

    // Cursor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= 7'd0;
            row_q <= 5'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign addr_o = ADDR_WIDTH'(32'(row_q) * COLS + 32'(col_q));

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - character RAM controller: serial writes, screen clear, port B arbitration
module text_buffer_ctrl
    import text_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    COLS       = DEF_COLS,
    parameter int                    ROWS       = DEF_ROWS,
    parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = DATA_WIDTH'(DEF_CLEAR_CHAR)
) (
    input  logic         clk,
    input  logic         rst,
    text_buffer_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  ram_wen_q;
    logic [ADDR_WIDTH-1:0] ram_addr_a_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic                  rb_pend_q;

    logic                  accept;
    logic                  is_cr, is_lf, is_bs, is_ff, is_print;
    logic                  clr_last;
    logic [ADDR_WIDTH-1:0] cur_addr;

    assign accept   = (state_q == ST_IDLE) && bus.wr_valid;
    assign is_cr    = (bus.wr_data == DATA_WIDTH'(CHAR_CR));
    assign is_lf    = (bus.wr_data == DATA_WIDTH'(CHAR_LF));
    assign is_bs    = (bus.wr_data == DATA_WIDTH'(CHAR_BS));
    assign is_ff    = (bus.wr_data == DATA_WIDTH'(CHAR_FF));
    assign is_print = !(is_cr || is_lf || is_bs || is_ff);
    assign clr_last = (state_q == ST_CLEAR) && (clr_cnt_q == LAST_ADDR);

    text_cursor #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .COLS      (COLS),
        .ROWS      (ROWS)
    ) u_cursor (
        .clk      (clk),
        .rst      (rst),
        .advance_i(accept && is_print),
        .cr_i     (accept && is_cr),
        .lf_i     (accept && is_lf),
        .bs_i     (accept && is_bs),
        .home_i   (clr_last),
        .col_o    (bus.cursor_col),
        .row_o    (bus.cursor_row),
        .addr_o   (cur_addr)
    );

    // Clear sequencer and port A write register; one RAM write per cycle at most
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            ram_wen_q    <= 1'b0;
            ram_addr_a_q <= '0;
            ram_din_q    <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ram_wen_q    <= 1'b1;
                    ram_addr_a_q <= clr_cnt_q;
                    ram_din_q    <= CLEAR_CHAR;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    ram_wen_q <= 1'b0;
                    if (accept) begin
                        if (is_ff) begin
                            state_q   <= ST_CLEAR;
                            clr_cnt_q <= '0;
                        end else if (is_print) begin
                            ram_wen_q    <= 1'b1;
                            ram_addr_a_q <= cur_addr;
                            ram_din_q    <= bus.wr_data;
                        end
                    end
                end
            endcase
        end
    end

    // Readback pending flag: RAM data for an accepted readback arrives next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_pend_q <= 1'b0;
        end else begin
            rb_pend_q <= bus.rb_valid && !bus.vga_ren;
        end
    end

    assign bus.busy       = (state_q == ST_CLEAR);
    assign bus.wr_ready   = (state_q == ST_IDLE);
    assign bus.ram_wen    = ram_wen_q;
    assign bus.ram_addr_a = ram_addr_a_q;
    assign bus.ram_din    = ram_din_q;

    // VGA fetch always owns port B when it asks; readback takes leftover cycles
    assign bus.ram_ren       = bus.vga_ren || bus.rb_valid;
    assign bus.ram_addr_b    = bus.vga_ren ? bus.vga_addr : bus.rb_addr;
    assign bus.rb_ready      = bus.rb_valid && !bus.vga_ren;
    assign bus.vga_data      = bus.ram_dout;
    assign bus.rb_data       = bus.ram_dout;
    assign bus.rb_data_valid = rb_pend_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - directed self-checking bench for text_buffer_ctrl
module tb_text_buffer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    text_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) bus ();

    text_buffer_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(12),
        .COLS      (80),
        .ROWS      (30),
        .CLEAR_CHAR(8'h20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] mem [0:4095];

    // Block RAM model: write port A, read port B with one-cycle latency, old data on collision
    always @(posedge clk) begin
        if (bus.ram_wen) mem[bus.ram_addr_a] <= bus.ram_din;
        if (bus.ram_ren) bus.ram_dout <= mem[bus.ram_addr_b];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch);
        bus.wr_valid = 1'b1;
        bus.wr_data  = ch;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic check_cursor(input string tag, input int row, input int col);
        check({tag, "_row"}, 32'(bus.cursor_row), 32'(row));
        check({tag, "_col"}, 32'(bus.cursor_col), 32'(col));
    endtask

    // Follows a clear from its first cycle to the first IDLE cycle
    task automatic run_clear(input string tag);
        int busy_cnt = 0;
        int wr_cnt   = 0;
        int bad      = 0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.ram_wen) begin
                if (32'(bus.ram_addr_a) != wr_cnt || bus.ram_din != 8'h20) bad++;
                wr_cnt++;
            end
            if (!bus.busy) break;
            if (bus.wr_ready) bad++;
            busy_cnt++;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd2400);
        check({tag, "_writes"}, 32'(wr_cnt), 32'd2400);
        check({tag, "_bad_writes"}, 32'(bad), 32'd0);
        check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        check_cursor({tag, "_home"}, 0, 0);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.vga_ren  = 1'b0;
        bus.vga_addr = 12'd0;
        bus.rb_valid = 1'b0;
        bus.rb_addr  = 12'd0;

        rst = 1'b1;
        repeat (3) step();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        check("rst_ram_addr_a", 32'(bus.ram_addr_a), 32'd0);
        check("rst_ram_din", 32'(bus.ram_din), 32'd0);
        check("rst_rb_data_valid", 32'(bus.rb_data_valid), 32'd0);
        check_cursor("rst", 0, 0);
        rst = 1'b0;
        run_clear("boot");

        // Back-to-back printable characters
        send(8'h41);
        check("a_wen", 32'(bus.ram_wen), 32'd1);
        check("a_addr", 32'(bus.ram_addr_a), 32'd0);
        check("a_din", 32'(bus.ram_din), 32'h41);
        send(8'h42);
        check("b_wen", 32'(bus.ram_wen), 32'd1);
        check("b_addr", 32'(bus.ram_addr_a), 32'd1);
        check("b_din", 32'(bus.ram_din), 32'h42);
        check_cursor("ab", 0, 2);
        step();
        check("idle_wen", 32'(bus.ram_wen), 32'd0);

        // Move to the bottom-right cell and wrap the whole screen
        for (int i = 0; i < 77; i++) send(8'h2A);
        check_cursor("eol", 0, 79);
        for (int i = 0; i < 29; i++) send(8'h0A);
        check("lf_wen", 32'(bus.ram_wen), 32'd0);
        check_cursor("last_cell", 29, 79);
        send(8'h5A);
        check("z_wen", 32'(bus.ram_wen), 32'd1);
        check("z_addr", 32'(bus.ram_addr_a), 32'd2399);
        check("z_din", 32'(bus.ram_din), 32'h5A);
        check_cursor("wrap", 0, 0);

        // Column wrap into row 1
        for (int i = 0; i < 80; i++) send(8'h2E);
        send(8'h51);
        check("c81_addr", 32'(bus.ram_addr_a), 32'd80);
        check("c81_din", 32'(bus.ram_din), 32'h51);
        check_cursor("c81", 1, 1);

        // Control codes from (3,10)
        send(8'h0A);
        send(8'h0A);
        send(8'h0D);
        for (int i = 0; i < 10; i++) send(8'h61);
        check_cursor("pos_3_10", 3, 10);
        send(8'h08);
        check("bs_wen", 32'(bus.ram_wen), 32'd0);
        check_cursor("bs", 3, 9);
        send(8'h0D);
        check("cr_wen", 32'(bus.ram_wen), 32'd0);
        check_cursor("cr", 3, 0);
        send(8'h0A);
        check_cursor("lf1", 4, 0);
        send(8'h0A);
        check("lf2_wen", 32'(bus.ram_wen), 32'd0);
        check_cursor("lf2", 5, 0);
        send(8'h08);
        check_cursor("bs_col0", 5, 0);

        // Port B arbitration: VGA wins, readback follows
        bus.vga_ren  = 1'b1;
        bus.vga_addr = 12'd100;
        bus.rb_valid = 1'b1;
        bus.rb_addr  = 12'd5;
        #1;
        check("arb_addr_vga", 32'(bus.ram_addr_b), 32'd100);
        check("arb_ren", 32'(bus.ram_ren), 32'd1);
        check("arb_rb_ready0", 32'(bus.rb_ready), 32'd0);
        step();
        check("vga_data", 32'(bus.vga_data), 32'h20);
        check("rb_stall_valid", 32'(bus.rb_data_valid), 32'd0);
        bus.vga_ren = 1'b0;
        #1;
        check("arb_addr_rb", 32'(bus.ram_addr_b), 32'd5);
        check("arb_rb_ready1", 32'(bus.rb_ready), 32'd1);
        step();
        bus.rb_valid = 1'b0;
        check("rb_valid", 32'(bus.rb_data_valid), 32'd1);
        check("rb_data", 32'(bus.rb_data), 32'h2E);
        step();
        check("rb_valid_drop", 32'(bus.rb_data_valid), 32'd0);

        // Form feed, then reset partway through the clear
        send(8'h0C);
        check("ff_wen", 32'(bus.ram_wen), 32'd0);
        check("ff_busy", 32'(bus.busy), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h58;
        begin
            int rdy_seen = 0;
            for (int i = 0; i < 1000; i++) begin
                step();
                if (bus.wr_ready) rdy_seen++;
            end
            check("ff_wr_ready", 32'(rdy_seen), 32'd0);
        end
        check("ff_mid_addr", 32'(bus.ram_addr_a), 32'd999);
        check("ff_mid_din", 32'(bus.ram_din), 32'h20);
        check_cursor("ff_mid", 5, 0);
        rst = 1'b1;
        step();
        check("ff_rst_wen", 32'(bus.ram_wen), 32'd0);
        check("ff_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        run_clear("restart");
        bus.wr_valid = 1'b0;
        step();
        check("end_wen", 32'(bus.ram_wen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Owns the dual-port character RAM that backs the VGA text display.
- Turns a serial-receive character stream into cursor-addressed writes on RAM port A, with control-character handling and a sequenced screen clear.
- Shares RAM read port B between the VGA character fetch (priority) and a host readback requester.
- Sits between the UART receiver / VGA timing logic and the block RAM instance.

Parameters:
- DATA_WIDTH, 8, character code width.
- ADDR_WIDTH, 12, RAM address width; 2**ADDR_WIDTH >= COLS*ROWS.
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- CLEAR_CHAR, 8'h20, fill value written by a clear.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  character available from serial side.
- wr_ready  out  1  controller accepts character this cycle.
- wr_data  in  DATA_WIDTH  character code.
- vga_ren  in  1  VGA fetch request.
- vga_addr  in  ADDR_WIDTH  VGA fetch address.
- vga_data  out  DATA_WIDTH  fetched character, valid one cycle after vga_ren.
- rb_valid  in  1  readback request.
- rb_ready  out  1  readback request accepted this cycle.
- rb_addr  in  ADDR_WIDTH  readback address.
- rb_data  out  DATA_WIDTH  readback data.
- rb_data_valid  out  1  one-cycle pulse, rb_data valid.
- ram_wen  out  1  RAM port A write enable (registered).
- ram_addr_a  out  ADDR_WIDTH  RAM port A address (registered).
- ram_din  out  DATA_WIDTH  RAM port A data (registered).
- ram_ren  out  1  RAM port B read enable (combinational).
- ram_addr_b  out  ADDR_WIDTH  RAM port B address (combinational).
- ram_dout  in  DATA_WIDTH  RAM port B data, one-cycle read latency.
- cursor_col  out  7  current column, 0..COLS-1.
- cursor_row  out  5  current row, 0..ROWS-1.
- busy  out  1  high while clearing.

Behaviour:
- Reset:
  - While rst=1: state=CLEAR, clear counter=0, ram_wen=0, ram_addr_a=0, ram_din=0, cursor=(0,0), rb_data_valid=0, busy=1, wr_ready=0.
  - After release the clear runs.
- FSM states:
  - CLEAR: one write per cycle, ram_wen=1, ram_din=CLEAR_CHAR, addresses 0..COLS*ROWS-1 ascending.
    - After writing COLS*ROWS-1: cursor=(0,0), go to IDLE.
    - busy=1 and wr_ready=0 throughout.
  - IDLE: wr_ready=1. Accept on wr_valid&&wr_ready; throughput is 1 char/cycle.
- Write path:
  - Accepted printable char (any code not listed below): next cycle ram_wen=1, ram_addr_a=row*COLS+col (cursor at acceptance), ram_din=wr_data.
  - Cursor advances on the same edge. col wraps COLS-1 -> 0 with row+1; row wraps ROWS-1 -> 0. No scrolling.
  - Address is computed from registered row/col; the constant multiply result is truncated to ADDR_WIDTH.
- Control codes (no RAM write, ram_wen=0 next cycle):
  - 0x0D CR: col=0.
  - 0x0A LF: row+1, wrap ROWS-1 -> 0; col unchanged.
  - 0x08 BS: col-1 if col>0, else no change.
  - 0x0C FF: enter CLEAR from counter 0; cursor homes at the end of the clear.
- ram_wen is deasserted in any IDLE cycle without acceptance.
- Port B arbitration (combinational):
  - ram_ren = vga_ren | rb_valid.
  - ram_addr_b = vga_ren ? vga_addr : rb_addr.
  - rb_ready = rb_valid & ~vga_ren. VGA always wins; readback stalls with no starvation guarantee (VGA blanking provides gaps).
- Readback and VGA data:
  - An accepted readback sets a pending flag; the next cycle gives rb_data_valid=1 and rb_data=ram_dout.
  - vga_data = ram_dout, unregistered.
  - Readback and VGA reads are unaffected by CLEAR.
- Read-during-write to the same address in one cycle returns old data; this is not hidden.
- Reset mid-CLEAR restarts the clear at address 0. Reset mid-readback drops the pending rb_data_valid.

Decomposition:
- Package text_buffer_pkg:
  - FSM state enum (IDLE, CLEAR).
  - Control-code constants CHAR_CR, CHAR_LF, CHAR_BS, CHAR_FF.
  - Default COLS/ROWS/CLEAR_CHAR.
- One sub-module, text_cursor: holds row/col and applies advance, CR, LF, BS and home with wrap rules; outputs the linear address.
- Port B arbitration stays inline.

Test Plan:
- Reset release -> busy=1 for exactly 2400 cycles; ram_wen=1 with ram_din=0x20 for addresses 0..2399 in order; then wr_ready=1 and cursor=(0,0).
- Send 'A','B' back-to-back -> ram_wen on the two following cycles at addr 0/0x41 and addr 1/0x42; cursor_col=2.
- With cursor at (29,79), send 'Z' -> write addr 2399 data 0x5A; cursor=(0,0). 81 chars from home -> 81st char written at addr 80.
- Cursor at (3,10): send BS, CR, LF, LF -> no ram_wen; cursor becomes (3,9), (3,0), (4,0), (5,0). BS at col 0 leaves col at 0.
- vga_ren=1 with addr 100 and rb_valid=1 with addr 5 in the same cycle -> ram_addr_b=100, rb_ready=0. Next cycle with vga_ren=0 -> ram_addr_b=5, rb_ready=1. rb_data_valid=1 one cycle later with the stored char.
- Send FF, then assert rst for 1 cycle at clear count 1000 -> after release the clear restarts at addr 0 and completes in 2400 cycles; wr_ready stays 0 until completion.
